// File: rtl/wgt_buf_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wgt_buf_responder_pkg
// Brief    : Shared sizing constants, FSM encoding and helpers for the
//            weight-buffer read responder.
// Revision : 1.0 - initial release
// ============================================================================
package wgt_buf_responder_pkg;

    localparam int ADDR_WIDTH  = 9;
    localparam int DATA_WIDTH  = 8;
    localparam int LANES       = 16;
    localparam int LANE_BITS   = $clog2(LANES);
    localparam int ROW_WIDTH   = ADDR_WIDTH - LANE_BITS;
    localparam int CNT_WIDTH   = ROW_WIDTH + 1;
    localparam int DRAIN_WIDTH = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    // Request counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wgt_buf_responder_bank.sv
`default_nettype none
// ============================================================================
// Module   : wgt_bank
// Brief    : One weight bank: synchronous read-first RAM, one write port and
//            one registered read port, ROW_WIDTH address bits deep.
// Revision : 1.0 - initial release
// ============================================================================
module wgt_bank
    import wgt_buf_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ROW_WIDTH-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ROW_WIDTH-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ROW_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Both updates are non-blocking, so a same-row read sees the old word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/wgt_buf_responder.sv
`default_nettype none
// ============================================================================
// Module   : wgt_buf_responder
// Brief    : Banked weight-buffer reader feeding the systolic array with a
//            diagonally skewed row per request, plus preload and burst report.
// Revision : 1.0 - initial release
// ============================================================================
module wgt_buf_responder
    import wgt_buf_responder_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        addr_valid,
    input  logic [ADDR_WIDTH-1:0]       wgt_addr,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic [LANES*DATA_WIDTH-1:0] wgt_data,
    output logic [LANES-1:0]            wgt_valid,
    output logic                        burst_done,
    output logic [CNT_WIDTH-1:0]        burst_len,
    output logic                        align_err
);

    logic [ROW_WIDTH-1:0]  w_rd_row;
    logic [ROW_WIDTH-1:0]  w_wr_row;
    logic [LANE_BITS-1:0]  w_wr_lane;
    logic [DATA_WIDTH-1:0] w_bank_rdata [LANES];

    logic rd_vld_q, rd_vld_d;

    assign w_rd_row  = wgt_addr[ADDR_WIDTH-1:LANE_BITS];
    assign w_wr_row  = wr_addr[ADDR_WIDTH-1:LANE_BITS];
    assign w_wr_lane = wr_addr[LANE_BITS-1:0];

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic w_we;
        assign w_we = wr_en && (w_wr_lane == LANE_BITS'(b));

        wgt_bank u_bank (
            .clk     (clk),
            .i_we    (w_we),
            .i_waddr (w_wr_row),
            .i_wdata (wr_data),
            .i_re    (addr_valid),
            .i_raddr (w_rd_row),
            .o_rdata (w_bank_rdata[b])
        );
    end

    // Tracks which cycle's bank output carries a requested row.
    always_comb begin
        rd_vld_d = addr_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_vld_d;
        end
    end

    // Lane i: i+1 register stages. Inner stages shift freely; only the last
    // stage gates its load on valid so an idle lane keeps its last weight.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [i:0]                 vld_q, vld_d;
        logic [i:0][DATA_WIDTH-1:0] dat_q, dat_d;

        always_comb begin
            vld_d = (i + 1)'({vld_q, rd_vld_q});
            dat_d = ((i + 1) * DATA_WIDTH)'({dat_q, w_bank_rdata[i]});
            if (!vld_d[i]) begin
                dat_d[i] = dat_q[i];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign wgt_data[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[i];
        assign wgt_valid[i]                         = vld_q[i];
    end

    state_e                 state_q, state_d;
    logic [DRAIN_WIDTH-1:0] drain_q, drain_d;
    logic [CNT_WIDTH-1:0]   req_cnt_q, req_cnt_d;
    logic                   burst_done_q, burst_done_d;
    logic [CNT_WIDTH-1:0]   burst_len_q, burst_len_d;
    logic                   align_err_q, align_err_d;

    // The drain count covers the skew depth, so the report fires only once
    // the last lane of the last request has been presented.
    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        req_cnt_d    = req_cnt_q;
        burst_done_d = 1'b0;
        burst_len_d  = burst_len_q;
        align_err_d  = align_err_q;

        if (addr_valid && (wgt_addr[LANE_BITS-1:0] != '0)) begin
            align_err_d = 1'b1;
        end

        if (addr_valid) begin
            state_d   = ST_ACTIVE;
            drain_d   = DRAIN_WIDTH'(LANES);
            req_cnt_d = sat_inc(req_cnt_q);
        end else begin
            unique case (state_q)
                ST_ACTIVE: begin
                    state_d = ST_DRAIN;
                    drain_d = drain_q - 1'b1;
                end
                ST_DRAIN: begin
                    if (drain_q != '0) begin
                        drain_d = drain_q - 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        if (req_cnt_q != '0) begin
                            burst_done_d = 1'b1;
                            burst_len_d  = req_cnt_q;
                        end
                        req_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            drain_q      <= '0;
            req_cnt_q    <= '0;
            burst_done_q <= 1'b0;
            burst_len_q  <= '0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            req_cnt_q    <= req_cnt_d;
            burst_done_q <= burst_done_d;
            burst_len_q  <= burst_len_d;
            align_err_q  <= align_err_d;
        end
    end

    assign burst_done = burst_done_q;
    assign burst_len  = burst_len_q;
    assign align_err  = align_err_q;

endmodule
`default_nettype wire

// File: tb/tb_wgt_buf_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_wgt_buf_responder
// Brief    : Directed bench with a cycle-level behavioural model of the
//            weight-buffer responder and literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wgt_buf_responder;
    import wgt_buf_responder_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        addr_valid;
    logic [ADDR_WIDTH-1:0]       wgt_addr;
    logic                        wr_en;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [DATA_WIDTH-1:0]       wr_data;
    logic [LANES*DATA_WIDTH-1:0] wgt_data;
    logic [LANES-1:0]            wgt_valid;
    logic                        burst_done;
    logic [CNT_WIDTH-1:0]        burst_len;
    logic                        align_err;

    always #5 clk = ~clk;

    wgt_buf_responder dut (
        .clk        (clk),
        .rst        (rst),
        .addr_valid (addr_valid),
        .wgt_addr   (wgt_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wgt_data   (wgt_data),
        .wgt_valid  (wgt_valid),
        .burst_done (burst_done),
        .burst_len  (burst_len),
        .align_err  (align_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: every request is remembered by the edge it was
    // sampled on; lane i shows the row read at edge n-1-i.
    int           n         = 0;
    int           hist_base = 0;
    bit           req_at [4096];
    logic [7:0]   req_dat [4096][16];
    logic [7:0]   mem_m [512];
    logic [7:0]   exp_dat [16];
    logic [15:0]  exp_vld   = '0;
    bit           exp_done  = 1'b0;
    logic [5:0]   exp_len   = '0;
    bit           exp_align = 1'b0;
    int           pending   = 0;
    int           last_req  = 0;
    bit           chk_en    = 1'b0;
    int           done_seen = 0;
    logic [5:0]   last_len  = '0;
    logic [127:0] exp_vec;

    always @(posedge clk) begin : model
        int rb;
        int e;
        n++;
        if (rst) begin
            hist_base = n;
            exp_vld   = '0;
            for (int i = 0; i < 16; i++) exp_dat[i] = 8'h00;
            exp_done  = 1'b0;
            exp_len   = '0;
            exp_align = 1'b0;
            pending   = 0;
            chk_en    = 1'b1;
        end else begin
            req_at[n] = addr_valid;
            if (addr_valid) begin
                rb = (int'(wgt_addr) / 16) * 16;
                for (int i = 0; i < 16; i++) req_dat[n][i] = mem_m[rb + i];
                if ((int'(wgt_addr) % 16) != 0) exp_align = 1'b1;
            end
            for (int i = 0; i < 16; i++) begin
                e = n - 1 - i;
                if (e > hist_base && req_at[e]) begin
                    exp_vld[i] = 1'b1;
                    exp_dat[i] = req_dat[e][i];
                end else begin
                    exp_vld[i] = 1'b0;
                end
            end
            exp_done = 1'b0;
            if (addr_valid) begin
                if (pending < 63) pending++;
                last_req = n;
            end else if (pending > 0 && n == last_req + LANES + 1) begin
                exp_done = 1'b1;
                exp_len  = 6'(pending);
                pending  = 0;
            end
        end
        if (wr_en) mem_m[wr_addr] = wr_data;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 16; i++) exp_vec[i*8 +: 8] = exp_dat[i];
            check("valid", wgt_valid, exp_vld);
            check("data", wgt_data, exp_vec);
            check("done", burst_done, exp_done);
            if (exp_done) check("len", burst_len, exp_len);
            check("align", align_err, exp_align);
            if (burst_done) begin
                done_seen++;
                last_len = burst_len;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int a);
        addr_valid = 1'b1;
        wgt_addr   = 9'(a);
        tick();
        addr_valid = 1'b0;
    endtask

    initial begin
        int d0;
        rst = 1'b1; addr_valid = 1'b0; wgt_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("lit_rst_valid", wgt_valid, 0);
        check("lit_rst_data", wgt_data, 0);
        check("lit_rst_done", burst_done, 0);
        check("lit_rst_len", burst_len, 0);
        check("lit_rst_align", align_err, 0);

        for (int k = 0; k < 512; k++) begin
            wr_en = 1'b1; wr_addr = 9'(k); wr_data = 8'(k);
            tick();
        end
        wr_en = 1'b0;
        tick();

        // Single request: one lane per cycle, report 17 edges later.
        req(32);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k <= 16) begin
                check("lit_single_vld", wgt_valid, 128'(16'h1 << (k - 1)));
                check("lit_single_dat", wgt_data[(k-1)*8 +: 8], 32 + k - 1);
                check("lit_single_nodone", burst_done, 0);
            end else begin
                check("lit_single_done", burst_done, 1);
                check("lit_single_len", burst_len, 1);
            end
        end
        repeat (3) tick();

        // 3x3x3 kernel burst.
        d0 = done_seen;
        addr_valid = 1'b1;
        for (int k = 0; k < 27; k++) begin
            wgt_addr = 9'(16 * k);
            tick();
        end
        addr_valid = 1'b0;
        repeat (16) tick();
        check("lit_b27_early", burst_done, 0);
        tick();
        check("lit_b27_done", burst_done, 1);
        check("lit_b27_len", burst_len, 27);
        repeat (3) tick();
        check("lit_b27_pulses", done_seen - d0, 1);

        // Misaligned request returns its row and sets the sticky flag.
        req(35);
        tick();
        check("lit_align_set", align_err, 1);
        check("lit_align_l0", wgt_data[7:0], 32);
        repeat (15) tick();
        check("lit_align_l15", wgt_data[127:120], 47);
        repeat (5) tick();

        // Read-first on a same-cycle write.
        addr_valid = 1'b1; wgt_addr = 9'd48;
        wr_en = 1'b1; wr_addr = 9'd48; wr_data = 8'hAA;
        tick();
        addr_valid = 1'b0; wr_en = 1'b0;
        tick();
        check("lit_rf_old", wgt_data[7:0], 48);
        repeat (20) tick();
        req(48);
        tick();
        check("lit_rf_new", wgt_data[7:0], 8'hAA);
        repeat (20) tick();

        // Short gap merges, long gap splits.
        d0 = done_seen;
        req(0); req(16); req(32);
        repeat (5) tick();
        req(48); req(64); req(80);
        repeat (25) tick();
        check("lit_merge_pulses", done_seen - d0, 1);
        check("lit_merge_len", last_len, 6);

        d0 = done_seen;
        req(0); req(16); req(32);
        repeat (20) tick();
        req(48); req(64); req(80);
        repeat (25) tick();
        check("lit_split_pulses", done_seen - d0, 2);
        check("lit_split_len", last_len, 3);

        // Request count saturates.
        addr_valid = 1'b1;
        for (int k = 0; k < 70; k++) begin
            wgt_addr = 9'(16 * (k % 32));
            tick();
        end
        addr_valid = 1'b0;
        repeat (25) tick();
        check("lit_sat_len", last_len, 63);
        check("lit_align_sticky", align_err, 1);

        // Reset mid-burst drops everything but keeps storage.
        d0 = done_seen;
        addr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wgt_addr = 9'(16 * k);
            tick();
        end
        rst = 1'b1; addr_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("lit_mrst_valid", wgt_valid, 0);
        check("lit_mrst_align", align_err, 0);
        repeat (25) tick();
        check("lit_mrst_nodone", done_seen - d0, 0);
        req(64);
        tick();
        check("lit_mrst_l0", wgt_data[7:0], 64);
        repeat (15) tick();
        check("lit_mrst_l15", wgt_data[127:120], 79);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
